// File: rtl/viterbi_sequencer.sv
// Viterbi decoder control sequencer.
// Accepts one coded frame, steps the datapath through extract/branch/add/memory
// for every symbol, waits (bounded) for traceback, then hands a byte downstream.
module viterbi_sequencer #(
  parameter int N_SYM      = 8,
  parameter int TB_TIMEOUT = 31
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [15:0] i_data,
  output logic        o_ready,
  output logic [15:0] o_frame,
  output logic        o_en_extract,
  output logic        o_en_branch,
  output logic        o_en_add,
  output logic        o_en_memory,
  output logic        o_en_traceback,
  output logic [2:0]  o_sym_idx,
  input  logic        i_tb_done,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_tb_timeout,
  output logic [7:0]  o_frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_TRACE,
    S_OUT
  } state_t;

  localparam logic [2:0] LAST_SYM  = 3'(N_SYM - 1);
  localparam logic [7:0] LAST_WAIT = 8'(TB_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  sym_q, sym_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  assign o_frame      = frame_q;
  assign o_sym_idx    = sym_q;
  assign o_tb_timeout = timeout_q;
  assign o_frame_cnt  = cnt_q;

  // Next-state, counter updates and Moore outputs for the current state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    phase_d        = phase_q;
    sym_d          = sym_q;
    wait_d         = wait_q;
    frame_d        = frame_q;
    cnt_d          = cnt_q;
    timeout_d      = timeout_q;
    o_ready        = 1'b0;
    o_valid        = 1'b0;
    o_en_extract   = 1'b0;
    o_en_branch    = 1'b0;
    o_en_add       = 1'b0;
    o_en_memory    = 1'b0;
    o_en_traceback = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          frame_d = i_data;
          sym_d   = '0;
          phase_d = '0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (phase_q)
          2'd0:    o_en_extract = 1'b1;
          2'd1:    o_en_branch  = 1'b1;
          2'd2:    o_en_add     = 1'b1;
          default: o_en_memory  = 1'b1;
        endcase
        // Phase 3 wraps to 0 naturally through the 2-bit add.
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (sym_q == LAST_SYM) begin
            wait_d  = '0;
            state_d = S_TRACE;
          end else begin
            sym_d = sym_q + 3'd1;
          end
        end
      end
      S_TRACE: begin
        o_en_traceback = 1'b1;
        // A done arriving on the timeout edge wins: the byte is still good.
        if (i_tb_done) begin
          state_d = S_OUT;
        end else if (wait_q == LAST_WAIT) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        o_valid = 1'b1;
        if (i_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_IDLE;
        end
      end
    endcase

    // Flush overrides everything above but preserves frame, count and flag.
    if (i_flush) begin
      state_d   = S_IDLE;
      phase_d   = '0;
      sym_d     = '0;
      wait_d    = '0;
      frame_d   = frame_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      sym_q     <= '0;
      wait_q    <= '0;
      frame_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      sym_q     <= sym_d;
      wait_q    <= wait_d;
      frame_q   <= frame_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_viterbi_sequencer.sv
// Self-checking bench for viterbi_sequencer: directed scenarios followed by
// randomized traffic, all compared each cycle against a frame-level model.
module tb_viterbi_sequencer;

  localparam int N_SYM      = 8;
  localparam int TB_TIMEOUT = 31;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1, i_flush = 1'b0, i_valid = 1'b0;
  logic [15:0] i_data = '0;
  logic        i_tb_done = 1'b0, i_ready = 1'b0;
  logic        o_ready, o_valid, o_tb_timeout;
  logic [15:0] o_frame;
  logic        o_en_extract, o_en_branch, o_en_add, o_en_memory, o_en_traceback;
  logic [2:0]  o_sym_idx;
  logic [7:0]  o_frame_cnt;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 sys_clk = ~sys_clk;

  viterbi_sequencer #(.N_SYM(N_SYM), .TB_TIMEOUT(TB_TIMEOUT)) dut (
    .sys_clk(sys_clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid),
    .i_data(i_data), .o_ready(o_ready), .o_frame(o_frame),
    .o_en_extract(o_en_extract), .o_en_branch(o_en_branch), .o_en_add(o_en_add),
    .o_en_memory(o_en_memory), .o_en_traceback(o_en_traceback),
    .o_sym_idx(o_sym_idx), .i_tb_done(i_tb_done), .o_valid(o_valid),
    .i_ready(i_ready), .o_tb_timeout(o_tb_timeout), .o_frame_cnt(o_frame_cnt)
  );

  // Reference model: a frame is "decode cycle d of 4*N_SYM" or "trace cycle t".
  typedef enum int {M_IDLE, M_DEC, M_TRACE, M_OUT} mode_t;
  mode_t       m_mode = M_IDLE;
  int          m_dec = 0;     // cycles of DECODE already elapsed (0-based)
  int          m_trace = 0;   // 1-based index of the current TRACE cycle
  int          m_sym_hold = 0;
  logic [15:0] m_frame = '0;
  logic [7:0]  m_cnt = '0;
  logic        m_flag = 1'b0;

  // Observation counters for scenario-level checks.
  int obs_extract = 0, obs_decode = 0, obs_trace = 0, obs_valid = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_mode = M_IDLE; m_dec = 0; m_trace = 0; m_sym_hold = 0;
      m_frame = '0; m_cnt = '0; m_flag = 1'b0;
    end else if (i_flush) begin
      m_mode = M_IDLE; m_dec = 0; m_trace = 0; m_sym_hold = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (i_valid) begin
          m_frame = i_data; m_dec = 0; m_sym_hold = 0; m_mode = M_DEC;
        end
        M_DEC: begin
          if (m_dec == 4 * N_SYM - 1) begin
            m_mode = M_TRACE; m_trace = 1; m_sym_hold = N_SYM - 1;
          end else m_dec++;
        end
        M_TRACE: begin
          if (i_tb_done) m_mode = M_OUT;
          else if (m_trace == TB_TIMEOUT) begin
            m_flag = 1'b1; m_mode = M_IDLE;
          end else m_trace++;
        end
        default: if (i_ready) begin
          m_cnt = m_cnt + 8'd1; m_mode = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    int sym_exp;
    sym_exp = (m_mode == M_DEC) ? m_dec / 4 : m_sym_hold;
    check("ready", o_ready, m_mode == M_IDLE);
    check("valid", o_valid, m_mode == M_OUT);
    check("en_extract", o_en_extract, m_mode == M_DEC && m_dec % 4 == 0);
    check("en_branch", o_en_branch, m_mode == M_DEC && m_dec % 4 == 1);
    check("en_add", o_en_add, m_mode == M_DEC && m_dec % 4 == 2);
    check("en_memory", o_en_memory, m_mode == M_DEC && m_dec % 4 == 3);
    check("en_traceback", o_en_traceback, m_mode == M_TRACE);
    check("sym_idx", o_sym_idx, sym_exp);
    check("frame", o_frame, m_frame);
    check("frame_cnt", o_frame_cnt, m_cnt);
    check("tb_timeout", o_tb_timeout, m_flag);
    check("onehot_enables", $countones({o_en_extract, o_en_branch, o_en_add,
                                        o_en_memory, o_en_traceback}) <= 1, 1);
    if (o_en_extract) obs_extract++;
    if (o_en_extract | o_en_branch | o_en_add | o_en_memory) obs_decode++;
    if (o_en_traceback) obs_trace++;
    if (o_valid) obs_valid++;
  endtask

  task automatic step(input logic r, input logic f, input logic v, input logic [15:0] d,
                      input logic td, input logic rd);
    rst = r; i_flush = f; i_valid = v; i_data = d; i_tb_done = td; i_ready = rd;
    @(posedge sys_clk);
    model_update();
    @(negedge sys_clk);
    compare_all();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic run_until(input mode_t m, input int budget);
    int n;
    n = 0;
    while (m_mode != m && n < budget) begin
      idle_step();
      n++;
    end
    check("run_until_budget", m_mode == m, 1);
  endtask

  task automatic accept(input logic [15:0] d);
    step(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] cnt_before;
    int guard;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    check("reset_frame", o_frame, 16'h0);

    // Nominal frame: done on the third TRACE cycle, downstream ready.
    obs_extract = 0; obs_decode = 0; obs_valid = 0;
    accept(16'hB4E1);
    run_until(M_TRACE, 40);
    idle_step();
    idle_step();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    check("nom_frame", o_frame, 16'hB4E1);
    check("nom_decode_cycles", obs_decode, 32);
    check("nom_extracts", obs_extract, 8);
    check("nom_valid_cycles", obs_valid, 1);
    check("nom_frame_cnt", o_frame_cnt, 8'd1);

    // Traceback timeout.
    cnt_before = o_frame_cnt;
    obs_trace = 0;
    accept(16'h5A5A);
    run_until(M_TRACE, 40);
    run_until(M_IDLE, 60);
    check("to_trace_cycles", obs_trace, TB_TIMEOUT);
    check("to_flag", o_tb_timeout, 1'b1);
    check("to_ready", o_ready, 1'b1);
    check("to_cnt_same", o_frame_cnt, cnt_before);

    // Backpressure with an ignored new frame offered meanwhile.
    accept(16'hC3C3);
    run_until(M_TRACE, 40);
    obs_valid = 0;
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    check("bp_valid_cycles", obs_valid, 11);
    check("bp_frame_kept", o_frame, 16'hC3C3);

    // Flush at symbol 3, phase 2, then a fresh frame starts at symbol 0.
    accept(16'h0F0F);
    guard = 0;
    while (!(m_mode == M_DEC && m_dec == 14) && guard < 40) begin
      idle_step();
      guard++;
    end
    check("fl_at_sym3_ph2", o_sym_idx == 3'd3 && o_en_add, 1);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    check("fl_ready", o_ready, 1'b1);
    check("fl_frame_kept", o_frame, 16'h0F0F);
    accept(16'h7777);
    check("fl_restart_sym", o_sym_idx, 3'd0);
    check("fl_restart_extract", o_en_extract, 1'b1);
    run_until(M_IDLE, 80);

    // Build o_frame_cnt up to 5, then reset in TRACE with the flag set.
    guard = 0;
    while (m_cnt != 8'd5 && guard < 300) begin
      accept(16'($urandom));
      run_until(M_TRACE, 40);
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      guard++;
    end
    check("rs_pre_cnt", o_frame_cnt, 8'd5);
    check("rs_pre_flag", o_tb_timeout, 1'b1);
    accept(16'hABCD);
    run_until(M_TRACE, 40);
    idle_step();
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("rs_cnt", o_frame_cnt, 8'd0);
    check("rs_flag", o_tb_timeout, 1'b0);
    check("rs_frame", o_frame, 16'h0);
    check("rs_traceback", o_en_traceback, 1'b0);

    // Done arriving on the timeout edge wins.
    accept(16'h2468);
    run_until(M_TRACE, 40);
    guard = 0;
    while (m_trace != TB_TIMEOUT && guard < 60) begin
      idle_step();
      guard++;
    end
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("sim_out_valid", o_valid, 1'b1);
    check("sim_no_flag", o_tb_timeout, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0,
           1'($urandom), 16'($urandom), $urandom_range(0, 24) == 0, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/viterbi_sequencer.md
VITERBI_SEQUENCER -- requirements
Module: viterbi_sequencer

Interface
REQ-001 SHALL have parameter N_SYM, default 8: number of 2-bit symbols per frame (1..8).
REQ-002 SHALL have parameter TB_TIMEOUT, default 31: max cycles in TRACE waiting for i_tb_done (1..255).
REQ-003 SHALL have port sys_clk  in  1: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-005 SHALL have port i_flush  in  1: synchronous abort to IDLE.
REQ-006 SHALL have port i_valid  in  1: upstream frame available.
REQ-007 SHALL have port i_data  in  16: coded frame, symbol k in bits [2k+1:2k].
REQ-008 SHALL have port o_ready  out  1: sequencer accepts a frame.
REQ-009 SHALL have port o_frame  out  16: latched frame driven to the datapath.
REQ-010 SHALL have ports o_en_extract, o_en_branch, o_en_add, o_en_memory, o_en_traceback  out  1 each: datapath stage enables.
REQ-011 SHALL have port o_sym_idx  out  3: index of the symbol being decoded.
REQ-012 SHALL have port i_tb_done  in  1: traceback stage finished.
REQ-013 SHALL have port o_valid  out  1: decoded byte ready downstream.
REQ-014 SHALL have port i_ready  in  1: downstream accepts the byte.
REQ-015 SHALL have port o_tb_timeout  out  1: sticky flag, traceback timed out.
REQ-016 SHALL have port o_frame_cnt  out  8: count of delivered frames, wraps 255->0.

Function
REQ-017 SHALL implement states IDLE, DECODE, TRACE, OUT.
REQ-018 IDLE: o_ready=1, all enables 0; on edge with i_valid=1, latch i_data into o_frame, clear o_sym_idx and phase, go DECODE.
REQ-019 o_ready SHALL be 1 only in IDLE; i_valid in other states SHALL be ignored, with no latch and no side effect.
REQ-020 DECODE: 2-bit phase counter, 0=extract, 1=branch, 2=add, 3=memory; exactly the matching enable high, one cycle per phase.
REQ-021 At phase 3: if o_sym_idx==N_SYM-1, go TRACE; else increment o_sym_idx and set phase to 0.
REQ-022 DECODE SHALL last exactly 4*N_SYM cycles; the first o_en_extract is in the cycle after the accept edge.
REQ-023 o_frame SHALL be stable from accept until the next accept.
REQ-024 TRACE: o_en_traceback=1 every cycle; 8-bit wait counter starts at 0.
REQ-025 i_tb_done=1 in TRACE SHALL move to OUT; i_tb_done in any other state SHALL be ignored.
REQ-026 If the wait counter reaches TB_TIMEOUT without i_tb_done, set o_tb_timeout=1 and go IDLE; o_frame_cnt SHALL not change.
REQ-027 i_tb_done arriving on the same edge as the timeout SHALL take priority, giving OUT and no flag.
REQ-028 OUT: o_valid=1, all enables 0; hold until i_valid... correction: hold until i_ready=1, then go IDLE and increment o_frame_cnt.
REQ-029 Once raised, o_valid SHALL not drop without i_ready (no retraction).
REQ-030 At most one of the five enables SHALL be high in any cycle.
REQ-031 i_flush=1 SHALL, at the edge, go IDLE, clear o_sym_idx, the phase and wait counters, and o_valid; o_frame, o_frame_cnt and o_tb_timeout SHALL keep their values.
REQ-032 i_flush SHALL take priority over every other transition.
REQ-033 o_tb_timeout SHALL clear only by rst.

Reset
REQ-034 rst=1 at an edge SHALL give IDLE, o_ready=1, all enables 0, o_valid=0, o_sym_idx=0, o_frame=0, o_frame_cnt=0, o_tb_timeout=0.
REQ-035 rst SHALL take priority over i_flush and all inputs.
REQ-036 rst mid-DECODE or mid-TRACE SHALL drop all enables from the next cycle, with no partial completion.

Verification
REQ-037 Nominal: i_valid=1, i_data=16'hB4E1, N_SYM=8, i_tb_done 3 cycles into TRACE, i_ready=1 -> o_frame=16'hB4E1; 32 DECODE cycles with enable order E,B,A,M repeated 8 times; o_sym_idx 0..7; o_valid for 1 cycle; o_frame_cnt=1.
REQ-038 Timeout: i_tb_done never asserted -> o_en_traceback high for 31 cycles, o_tb_timeout=1, state IDLE, o_frame_cnt unchanged.
REQ-039 Backpressure: i_ready=0 for 10 cycles in OUT -> o_valid held 11 cycles; new i_valid with i_data=16'h1234 meanwhile leaves o_frame unchanged.
REQ-040 Flush at o_sym_idx=3, phase 2 -> next cycle IDLE, enables 0, o_ready=1; the next frame decodes from symbol 0.
REQ-041 Reset in TRACE with o_tb_timeout=1 and o_frame_cnt=5 -> all outputs return to their REQ-034 values.
REQ-042 Simultaneous: i_tb_done on the timeout edge -> OUT and o_tb_timeout=0; assertion check that enables are one-hot-or-zero for all tests.
